uart_rx: RTL and testbench
==========================

# uart_rx

Serial byte receiver for the UART firmware-download path. It sits directly upstream of `uart_debug`, between the `uart_rxd` pin and that module. It synchronises the asynchronous RX line, detects and validates start bits, and samples 8N1 frames at mid-bit. It delivers each good byte as a one-cycle strobe, and flags bad stop bits as framing errors.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate in bit/s.
- Derived, local: `N = CLK_FREQ / BAUD`, integer division, truncated. `H = N / 2`, truncated. N must be ≥ 4; elaboration fails otherwise.

Ports:
- `clk`  input  1  system clock, all logic on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `uart_rxd`  input  1  raw serial line; idles high; asynchronous to `clk`.
- `rx_data_o`  output  8  last correctly received byte, LSB = first data bit; holds its value between frames.
- `rx_valid_o`  output  1  one-cycle pulse when `rx_data_o` updates with a good byte.
- `rx_frame_err_o`  output  1  one-cycle pulse when the stop bit samples 0.
- `rx_busy_o`  output  1  high while a frame is in progress: state is START, DATA or STOP.

## Operation
- Synchroniser: two flops `s1`, `s2`, both reset to 1. A third flop `s2_d` holds the previous `s2`, also reset to 1. All internal sampling uses `s2` only.
- FSM states:
  - IDLE: leave when `s2_d == 1 && s2 == 0` (falling edge). Go to START and clear the bit counter `cnt` to 0.
  - START: `cnt` increments each cycle. When `cnt == H-1`, sample `s2`. If it is 0, the start bit is valid: go to DATA with `cnt = 0` and `bitidx = 0`. If it is 1, treat it as a glitch and return to IDLE with no error pulse.
  - DATA: when `cnt == N-1`, shift `s2` into `shreg[bitidx]` (LSB first), clear `cnt` and increment `bitidx`. After the 8th sample (`bitidx == 7` at sample time), go to STOP with `cnt = 0`.
  - STOP: when `cnt == N-1`, sample `s2`.
    - If it is 1: load `rx_data_o <= shreg` and pulse `rx_valid_o`.
    - If it is 0: pulse `rx_frame_err_o`; `rx_data_o` is unchanged.
    - In both cases go to IDLE.
- Re-arming needs a 1→0 edge on `s2`. A line held low after a framing error (break) never retriggers until it returns high and falls again.
- `rx_valid_o` and `rx_frame_err_o` are mutually exclusive. Each is high for exactly one cycle per frame.
- Counter widths: `cnt` is wide enough to hold N-1; `bitidx` is 3 bits. No wrap occurs inside a state.

## Timing
- Reset values: `rx_data_o = 8'h00`, `rx_valid_o = 0`, `rx_frame_err_o = 0`, `rx_busy_o = 0`, FSM = IDLE. Reset is applied immediately on `rst` low, including mid-frame.
- After reset release with the line low: no frame starts until a rising then falling transition is seen on `s2`.
- Pin-to-`s2` latency: 2 cycles. Edge detection adds 1 cycle: IDLE→START at edge E0.
- Sample points relative to E0:
  - start bit at E0+H;
  - data bit i at E0+H+(i+1)·N;
  - stop bit at E0+H+9·N.
- At the stop-sample edge, `rx_data_o`/`rx_valid_o` (or `rx_frame_err_o`) update and the FSM enters IDLE. Strobes drop at the next edge.
- `rx_busy_o` is registered with the state: it rises at E0 and falls at the start-glitch or stop-sample edge.
- Back-to-back frames: the next start edge may arrive any cycle after the stop sample. Because the FSM is already in IDLE at that point, no frame is lost.

## Test plan
- With CLK_FREQ=1_000_000, BAUD=100_000 (N=10, H=5):
  1. Send 0x55, 8N1 → exactly one `rx_valid_o` pulse, at E0+95; `rx_data_o = 0x55`; `rx_frame_err_o` stays 0; `rx_busy_o` high from E0 to E0+95.
  2. Send 0xA3, 0x0F, 0xFF, 0x00 back-to-back with 1 stop bit each → four valid pulses in order, with the matching byte on `rx_data_o` at each pulse; no errors.
  3. Drive a 3-cycle low glitch on an idle line → `rx_busy_o` pulses high, returns to 0 at the start sample; no valid, no error.
  4. After 0x55, send 0x3C with the stop bit 0, then hold the line low for 40 bit-times, then return it high → one `rx_frame_err_o` pulse, no valid, `rx_data_o` stays 0x55, and no further activity until a new falling edge. A following 0x7E is then received correctly.
  5. Assert `rst` low during data bit 4 of 0x81 → all outputs reset immediately, `rx_busy_o = 0`. After release, the remainder of that frame produces no valid pulse (line-high bits may start spurious frames but must not produce 0x81). A clean 0x7E sent after 2 idle bit-times is received as 0x7E.
- With default parameters (N=434, H=217):
  6. Send 0xC5 → `rx_valid_o` at E0+4123 with `rx_data_o = 0xC5`.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop synchroniser, falling-edge start detection,
// mid-bit sampling and one-cycle valid / framing-error strobes.
module uart_rx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rxd,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_frame_err_o,
  output logic       rx_busy_o
);

  localparam int N  = CLK_FREQ / BAUD;
  localparam int H  = N / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (N < 4) begin : g_bad_ratio
      $error("uart_rx: CLK_FREQ / BAUD must be at least 4");
    end
  endgenerate

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_nxt;
  logic            s1, s2, s2_d;
  logic [1:0]      fill;
  logic            armed;
  logic            fall;
  logic [CW-1:0]   cnt;
  logic [2:0]      bitidx;
  logic [7:0]      shreg;

  // fill/armed keep the reset value of s2 from counting as a real high level,
  // so a line held low through reset cannot fake a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      s2_d  <= 1'b1;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      s1   <= uart_rxd;
      s2   <= s1;
      s2_d <= s2;
      fill <= {fill[0], 1'b1};
      if (fill[1] && s2) armed <= 1'b1;
    end
  end

  assign fall = armed && s2_d && !s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (cnt == CNT_HALF) state_nxt = s2 ? IDLE : DATA;
      DATA:  if (cnt == CNT_FULL && bitidx == 3'd7) state_nxt = STOP;
      STOP:  if (cnt == CNT_FULL) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rx_busy_o = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      bitidx         <= 3'd0;
      shreg          <= 8'h00;
      rx_data_o      <= 8'h00;
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
    end else begin
      rx_valid_o     <= 1'b0;
      rx_frame_err_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt    <= '0;
          bitidx <= 3'd0;
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt    <= '0;
            bitidx <= 3'd0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_FULL) begin
            shreg[bitidx] <= s2;
            cnt           <= '0;
            bitidx        <= bitidx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (s2) begin
              rx_data_o  <= shreg;
              rx_valid_o <= 1'b1;
            end else begin
              rx_frame_err_o <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are generated from bit-level rules, expected
// strobes (kind, byte, cycle) are queued per instance and checked by monitors.
module tb_uart_rx;
  localparam int NA = 10;
  localparam int HA = 5;
  localparam int NB = 434;
  localparam int HB = 217;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line_a = 1'b1;
  logic       line_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       valid_a, err_a, busy_a;
  logic       valid_b, err_b, busy_b;

  uart_rx #(.CLK_FREQ(1_000_000), .BAUD(100_000)) dut_a (
    .clk(clk), .rst(rst), .uart_rxd(line_a),
    .rx_data_o(data_a), .rx_valid_o(valid_a),
    .rx_frame_err_o(err_a), .rx_busy_o(busy_a)
  );

  uart_rx dut_b (
    .clk(clk), .rst(rst), .uart_rxd(line_b),
    .rx_data_o(data_b), .rx_valid_o(valid_b),
    .rx_frame_err_o(err_b), .rx_busy_o(busy_b)
  );

  // clock / reset / cycle count
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // entry = {is_err, byte on rx_data_o, cycle of strobe}
  logic [40:0] exp_a[$];
  logic [40:0] exp_b[$];
  logic [7:0]  last_good[2];

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int unit, input logic v);
    if (unit == 0) line_a = v;
    else           line_b = v;
  endtask

  // driver: one 8N1 frame, bit time n cycles; the line is left at the stop level
  task automatic send_frame(input int unit, input logic [7:0] b, input logic stop_bit);
    int n, h, k;
    logic [40:0] e;
    n = (unit == 0) ? NA : NB;
    h = (unit == 0) ? HA : HB;
    k = cyc;
    e[31:0] = 32'(k + 3 + h + 9 * n);
    if (stop_bit) begin
      e[40]    = 1'b0;
      e[39:32] = b;
      last_good[unit] = b;
    end else begin
      e[40]    = 1'b1;
      e[39:32] = last_good[unit];
    end
    if (unit == 0) exp_a.push_back(e);
    else           exp_b.push_back(e);
    set_line(unit, 1'b0);
    tick(n);
    for (int i = 0; i < 8; i++) begin
      set_line(unit, b[i]);
      tick(n);
    end
    set_line(unit, stop_bit);
    tick(n);
  endtask

  task automatic busy_window(input int e0, input int len, input int span, input string name);
    int bad;
    logic want;
    bad = 0;
    for (int c = 0; c < span; c++) begin
      @(negedge clk);
      want = (cyc >= e0) && (cyc < e0 + len);
      if (busy_a !== want) bad++;
    end
    chk(name, bad, 0);
  endtask

  // scoreboard monitor
  task automatic mon(input int unit, input logic v, input logic e, input logic [7:0] d);
    logic [40:0] x;
    if (v && e) chk($sformatf("both_strobes_%0d", unit), 1, 0);
    if (v || e) begin
      if ((unit == 0 && exp_a.size() == 0) || (unit == 1 && exp_b.size() == 0)) begin
        chk($sformatf("unexpected_strobe_%0d err=%0b data", unit, e), d, 32'hFFFF_FFFF);
      end else begin
        x = (unit == 0) ? exp_a.pop_front() : exp_b.pop_front();
        chk($sformatf("strobe_kind_%0d", unit), e, x[40]);
        chk($sformatf("strobe_data_%0d", unit), d, x[39:32]);
        chk($sformatf("strobe_cycle_%0d", unit), cyc, x[31:0]);
      end
    end
  endtask

  always @(negedge clk) if (rst) mon(0, valid_a, err_a, data_a);
  always @(negedge clk) if (rst) mon(1, valid_b, err_b, data_b);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, bad, g;
    logic [7:0] b, r81;
    logic sb;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;

    tick(2);
    chk("reset_data", data_a, 8'h00);
    chk("reset_valid", valid_a, 0);
    chk("reset_err", err_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_data_b", data_b, 8'h00);
    rst = 1'b1;
    tick(5);

    // single frame with busy profile
    k = cyc;
    fork
      send_frame(0, 8'h55, 1'b1);
      busy_window(k + 3, 95, 100, "busy_frame");
    join
    tick(NA);

    // back-to-back frames
    send_frame(0, 8'hA3, 1'b1);
    send_frame(0, 8'h0F, 1'b1);
    send_frame(0, 8'hFF, 1'b1);
    send_frame(0, 8'h00, 1'b1);
    tick(2 * NA);

    // 3-cycle glitch on idle line
    k = cyc;
    fork
      begin
        line_a = 1'b0;
        tick(3);
        line_a = 1'b1;
      end
      busy_window(k + 3, 5, 14, "busy_glitch");
    join
    tick(2 * NA);

    // framing error followed by a long break
    send_frame(0, 8'h55, 1'b1);
    send_frame(0, 8'h3C, 1'b0);
    bad = 0;
    repeat (40 * NA) begin
      @(negedge clk);
      if (busy_a) bad++;
    end
    chk("busy_break", bad, 0);
    chk("data_after_break", data_a, 8'h55);
    line_a = 1'b1;
    tick(3 * NA);
    send_frame(0, 8'h7E, 1'b1);
    tick(2 * NA);

    // reset during data bit 4 of 0x81
    r81 = 8'h81;
    line_a = 1'b0;
    tick(NA);
    for (int i = 0; i < 4; i++) begin
      line_a = r81[i];
      tick(NA);
    end
    line_a = r81[4];
    tick(3);
    rst = 1'b0;
    #1;
    chk("midreset_data", data_a, 8'h00);
    chk("midreset_valid", valid_a, 0);
    chk("midreset_err", err_a, 0);
    chk("midreset_busy", busy_a, 0);
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    tick(2);
    rst = 1'b1;
    tick(NA - 5);
    for (int i = 5; i < 8; i++) begin
      line_a = r81[i];
      tick(NA);
    end
    line_a = 1'b1;
    tick(NA);
    tick(2 * NA);
    send_frame(0, 8'h7E, 1'b1);
    tick(NA);

    // randomized frames, occasional bad stop bit, random gaps
    for (int i = 0; i < 16; i++) begin
      b  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 4) != 0);
      send_frame(0, b, sb);
      g = sb ? $urandom_range(0, 15) : $urandom_range(2, 15);
      line_a = 1'b1;
      tick(g);
    end
    tick(2 * NA);

    // default-rate instance
    send_frame(1, 8'hC5, 1'b1);
    tick(20);

    chk("exp_a_drained", exp_a.size(), 0);
    chk("exp_b_drained", exp_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
